// File: rtl/sram_bist.sv
// Built-in self-test initiator for one SRAM arbiter user channel: writes an
// address-XOR-seed pattern over [0, words-1], reads it back and counts mismatches.
module sram_bist #(
    parameter int aw      = 19,
    parameter int dw      = 8,
    parameter int words   = 1024,
    parameter int timeout = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [dw-1:0] seed,
    output logic [aw-1:0] addr,
    output logic [dw-1:0] data_wr,
    output logic          en,
    output logic          we,
    input  logic          busy,
    input  logic [dw-1:0] data_rd,
    input  logic          valid,
    output logic          running,
    output logic          done,
    output logic          pass,
    output logic          timed_out,
    output logic [15:0]   err_count,
    output logic [aw-1:0] first_err_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ_REQ,
        S_READ_WAIT,
        S_DONE
    } state_t;

    localparam logic [aw-1:0] last_addr = aw'(words - 1);
    localparam logic [aw-1:0] addr_one  = aw'(1);
    localparam logic [15:0]   tmo_limit = 16'(timeout);
    localparam int            pw        = (aw < dw) ? aw : dw;

    // Expected data: low address bits (zero-extended when aw < dw) XOR seed.
    function automatic logic [dw-1:0] pattern(input logic [aw-1:0] a, input logic [dw-1:0] s);
        logic [dw-1:0] p;
        p         = '0;
        p[pw-1:0] = a[pw-1:0];
        return p ^ s;
    endfunction

    state_t        state_q, state_d;
    logic [aw-1:0] addr_q, addr_d;
    logic [dw-1:0] data_wr_q, data_wr_d;
    logic          en_q, en_d;
    logic          we_q, we_d;
    logic [dw-1:0] seed_q, seed_d;
    logic [15:0]   err_q, err_d;
    logic [aw-1:0] first_err_q, first_err_d;
    logic          timed_out_q, timed_out_d;
    logic [15:0]   tmo_q, tmo_d;
    logic          running_q, running_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through this block infers a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        data_wr_d   = data_wr_q;
        en_d        = en_q;
        we_d        = we_q;
        seed_d      = seed_q;
        err_d       = err_q;
        first_err_d = first_err_q;
        timed_out_d = timed_out_q;
        tmo_d       = tmo_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_WRITE;
                    addr_d      = '0;
                    seed_d      = seed;
                    data_wr_d   = pattern('0, seed);
                    en_d        = 1'b1;
                    we_d        = 1'b1;
                    err_d       = '0;
                    first_err_d = '0;
                    timed_out_d = 1'b0;
                end
            end
            S_WRITE: begin
                if (!busy) begin
                    if (addr_q == last_addr) begin
                        state_d = S_READ_REQ;
                        addr_d  = '0;
                        we_d    = 1'b0;
                    end else begin
                        addr_d    = addr_q + addr_one;
                        data_wr_d = pattern(addr_q + addr_one, seed_q);
                    end
                end
            end
            S_READ_REQ: begin
                if (!busy) begin
                    state_d = S_READ_WAIT;
                    en_d    = 1'b0;
                    tmo_d   = '0;
                end
            end
            S_READ_WAIT: begin
                if (valid) begin
                    if (data_rd != pattern(addr_q, seed_q)) begin
                        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                        if (err_q == 16'd0) first_err_d = addr_q;
                    end
                    if (addr_q == last_addr) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ_REQ;
                        addr_d  = addr_q + addr_one;
                        en_d    = 1'b1;
                    end
                end else if (tmo_q + 16'd1 == tmo_limit) begin
                    timed_out_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything but keeps the results of the interrupted run.
        if (abort) begin
            state_d     = S_IDLE;
            en_d        = 1'b0;
            we_d        = 1'b0;
            err_d       = err_q;
            first_err_d = first_err_q;
            timed_out_d = timed_out_q;
        end

        running_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d    = (state_d == S_DONE);
        pass_d    = done_d && (err_d == 16'd0) && !timed_out_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            data_wr_q   <= '0;
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            seed_q      <= '0;
            err_q       <= '0;
            first_err_q <= '0;
            timed_out_q <= 1'b0;
            tmo_q       <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register sees pre-edge values of the others.
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_wr_q   <= data_wr_d;
            en_q        <= en_d;
            we_q        <= we_d;
            seed_q      <= seed_d;
            err_q       <= err_d;
            first_err_q <= first_err_d;
            timed_out_q <= timed_out_d;
            tmo_q       <= tmo_d;
            running_q   <= running_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign addr           = addr_q;
    assign data_wr        = data_wr_q;
    assign en             = en_q;
    assign we             = we_q;
    assign running        = running_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timed_out      = timed_out_q;
    assign err_count      = err_q;
    assign first_err_addr = first_err_q;

endmodule

// File: doc/sram_bist.md
# sram_bist

Built-in self-test initiator for the SRAM arbiter's user channel. It drives the channel's request side (address, write data, enable, write enable) and consumes its response side (busy, read data, read valid). Each run writes a deterministic pattern to a contiguous address range, reads the range back and compares it. It is used at board bring-up and in simulation against the SRAM memory model. It sits on channel 0 in place of normal user logic, which is selected by a top-level mux.

## Interface
Parameters:
- aw, 19, address width
- dw, 8, data width
- words, 1024, number of words tested, starting at address 0; legal range 1 to 2**aw
- timeout, 255, maximum cycles spent waiting for read valid before the run aborts; legal range 1 to 65535

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle pulse that begins a run; honored only in IDLE or DONE
- abort  in  1  returns the block to IDLE from any state
- seed  in  dw  pattern seed, sampled on start
- addr  out  aw  to arbiter addra
- data_wr  out  dw  to arbiter data_wr
- en  out  1  to arbiter ena
- we  out  1  to arbiter wea
- busy  in  1  from arbiter busya
- data_rd  in  dw  from arbiter data_rd
- valid  in  1  from arbiter valida
- running  out  1  high in any state except IDLE and DONE
- done  out  1  high in DONE
- pass  out  1  meaningful only while done=1: 1 when err_count=0 and timed_out=0
- timed_out  out  1  set when the read-valid timeout expires
- err_count  out  16  number of mismatches, saturates at 0xFFFF
- first_err_addr  out  aw  address of the first mismatch; 0 if there was none

## Operation
- Pattern: expected(a) = a[dw-1:0] XOR seed_q. seed_q is latched on start. If aw < dw, a is zero-extended.
- Acceptance: a request is accepted in any cycle where en=1 and busy=0. While busy=1, addr, data_wr and we stay stable.
- States:
  - IDLE: en=0. start moves to WRITE: clears counters and flags, sets addr=0.
  - WRITE: en=1, we=1, data_wr=expected(addr).
    - On acceptance with addr=words-1: go to READ_REQ with addr=0.
    - Otherwise: increment addr.
  - READ_REQ: en=1, we=0. On acceptance go to READ_WAIT; the timeout counter is cleared.
  - READ_WAIT: en=0. Each cycle without valid increments the timeout counter.
    - valid=1: compare data_rd with expected(addr). On mismatch, err_count increments (saturating). On the first mismatch, first_err_addr is set to addr.
    - After the compare: if addr=words-1, go to DONE; otherwise increment addr and go to READ_REQ.
    - Counter reaching timeout with no valid: timed_out=1, go to DONE.
  - DONE: en=0. Results hold. start begins a new run, identical to starting from IDLE.
- Only one read is outstanding at any time. valid in any state other than READ_WAIT is ignored.
- start while running is ignored.
- abort has priority over start and over every transition. It leads to IDLE, forces en=0, and clears done. It leaves err_count, first_err_addr and timed_out unchanged.
- addr never wraps: the run ends at words-1.

## Timing
- Reset values: addr=0, data_wr=0, en=0, we=0, running=0, done=0, pass=0, timed_out=0, err_count=0, first_err_addr=0. State is IDLE.
- Reset asserted mid-run takes effect immediately (asynchronous). It overrides abort and start.
- All outputs are registered. en rises in the cycle after start is sampled.
- With busy=0 throughout: one write per cycle, so the write phase takes words cycles.
- Each read costs 1 (request) + L + 1 cycles, where L is the arbiter's cycles from acceptance to valid.
- done and pass are valid in the cycle after the last compare, or after the timeout expires.
- Compare, error count update and the DONE transition use data_rd from the same cycle in which valid=1.

## Test plan
- words=16, seed=0x5A, ideal memory model with latency 1 → 16 writes with data 0x5A, 0x5B, …; reads return the same values; done=1, pass=1, err_count=0.
- Same setup with data_rd[0] forced to 0 → err_count=8, first_err_addr=1, pass=0.
- busy held high for 5 cycles while the write to addr 3 is pending → addr=3 and data_wr=0x59 stay stable for those cycles; no address is skipped; pass=1.
- valid never asserted → timed_out=1 and done=1 exactly 255 waiting cycles after the first read is accepted; pass=0.
- abort pulsed during READ_WAIT → en=0 and the block is in IDLE by the next cycle; a following start runs to pass=1.
- rst asserted mid-write, then start → all outputs take their reset values immediately; the new run completes with pass=1; start pulsed while running has no effect.
